// File: rtl/monitor_pkg.sv
// Shared constants, types and width helpers for the multi-zone device tracker.
package monitor_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    typedef enum logic {
        ALARM_IDLE = 1'b0,
        ALARM_ON   = 1'b1
    } alarm_state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Sum of NUM_ZONES counters of WIDTH bits can never exceed this width.
    function automatic int total_width(input int width, input int num_zones);
        return width + clog2(num_zones);
    endfunction

endpackage

// File: rtl/active_device_tracker_if.sv
// Zone event inputs and status outputs of the device tracker.
interface active_device_tracker_if #(
    parameter int WIDTH     = 8,
    parameter int NUM_ZONES = 4
);
    import monitor_pkg::*;

    localparam int TOTAL_W = total_width(WIDTH, NUM_ZONES);

    logic [NUM_ZONES-1:0]       change;
    logic [NUM_ZONES-1:0]       on_off;
    logic [NUM_ZONES-1:0]       clr_err;
    logic [NUM_ZONES*WIDTH-1:0] count_out;
    logic [TOTAL_W-1:0]         total_out;
    logic [NUM_ZONES-1:0]       alarm;
    logic [NUM_ZONES-1:0]       err;

    modport master (
        output change, on_off, clr_err,
        input  count_out, total_out, alarm, err
    );

    modport slave (
        input  change, on_off, clr_err,
        output count_out, total_out, alarm, err
    );

endinterface

// File: rtl/zone_counter.sv
// One zone: up/down counter with wrap or clamp limits, sticky range error and
// hysteresis alarm evaluated on the registered count.
module zone_counter
    import monitor_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = MODE_WRAP,
    parameter int ALARM_HI = 200,
    parameter int ALARM_LO = 150
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             change,
    input  logic             on_off,
    input  logic             clr_err,
    output logic [WIDTH-1:0] count,
    output logic             alarm,
    output logic             err
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] HI_W    = WIDTH'(ALARM_HI);
    localparam logic [WIDTH-1:0] LO_W    = WIDTH'(ALARM_LO);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             err_reg;
    logic             err_next;
    logic             range_evt;
    logic             alarm_reg;
    alarm_state_t     state_reg;

    always_comb begin
        count_next = count_reg;
        range_evt  = 1'b0;
        if (change) begin
            if (on_off) begin
                range_evt = (count_reg == CNT_MAX);
                if (!(range_evt && SATURATE == MODE_SAT))
                    count_next = count_reg + 1'b1;
            end else begin
                range_evt = (count_reg == '0);
                if (!(range_evt && SATURATE == MODE_SAT))
                    count_next = count_reg - 1'b1;
            end
        end
        // A fresh range event beats a simultaneous clear.
        err_next = range_evt ? 1'b1 : (clr_err ? 1'b0 : err_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ALARM_IDLE;
            alarm_reg <= 1'b0;
        end else begin
            case (state_reg)
                ALARM_IDLE: if (count_reg >= HI_W) begin
                    state_reg <= ALARM_ON;
                    alarm_reg <= 1'b1;
                end
                ALARM_ON: if (count_reg <= LO_W) begin
                    state_reg <= ALARM_IDLE;
                    alarm_reg <= 1'b0;
                end
                default: begin
                    state_reg <= ALARM_IDLE;
                    alarm_reg <= 1'b0;
                end
            endcase
        end
    end

    assign count = count_reg;
    assign err   = err_reg;
    assign alarm = alarm_reg;

endmodule

// File: rtl/active_device_tracker.sv
// Multi-zone active device tracker: one zone_counter per zone plus a
// registered full-width total of all zone counts.
module active_device_tracker
    import monitor_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_ZONES = 4,
    parameter int SATURATE  = MODE_WRAP,
    parameter int ALARM_HI  = 200,
    parameter int ALARM_LO  = 150
) (
    input  logic                    clk,
    input  logic                    rst,
    active_device_tracker_if.slave  bus
);

    localparam int TOTAL_W = total_width(WIDTH, NUM_ZONES);

    logic [NUM_ZONES*WIDTH-1:0] count_all;
    logic [NUM_ZONES-1:0]       alarm_all;
    logic [NUM_ZONES-1:0]       err_all;
    logic [TOTAL_W-1:0]         partial_sum [NUM_ZONES+1];
    logic [TOTAL_W-1:0]         total_reg;

    assign partial_sum[0] = '0;

    for (genvar gi = 0; gi < NUM_ZONES; gi++) begin : g_zone
        zone_counter #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE),
            .ALARM_HI (ALARM_HI),
            .ALARM_LO (ALARM_LO)
        ) u_zone (
            .clk     (clk),
            .rst     (rst),
            .change  (bus.change[gi]),
            .on_off  (bus.on_off[gi]),
            .clr_err (bus.clr_err[gi]),
            .count   (count_all[gi*WIDTH +: WIDTH]),
            .alarm   (alarm_all[gi]),
            .err     (err_all[gi])
        );

        assign partial_sum[gi+1] = partial_sum[gi] + TOTAL_W'(count_all[gi*WIDTH +: WIDTH]);
    end

    // Total is taken from the registered counts, so it trails count_out by a cycle.
    always_ff @(posedge clk) begin
        if (rst) total_reg <= '0;
        else     total_reg <= partial_sum[NUM_ZONES];
    end

    assign bus.count_out = count_all;
    assign bus.alarm     = alarm_all;
    assign bus.err       = err_all;
    assign bus.total_out = total_reg;

endmodule

// File: tb/tb_active_device_tracker.sv
// Directed bench: identical stimulus drives a wrap-mode and a saturate-mode tracker.
module tb_active_device_tracker;
    import monitor_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    active_device_tracker_if #(.WIDTH(8), .NUM_ZONES(4)) wif ();
    active_device_tracker_if #(.WIDTH(8), .NUM_ZONES(4)) sif ();

    active_device_tracker #(
        .WIDTH(8), .NUM_ZONES(4), .SATURATE(MODE_WRAP), .ALARM_HI(200), .ALARM_LO(150)
    ) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (wif.slave)
    );

    active_device_tracker #(
        .WIDTH(8), .NUM_ZONES(4), .SATURATE(MODE_SAT), .ALARM_HI(200), .ALARM_LO(150)
    ) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int zw(input int z);
        return int'(wif.count_out[z*8 +: 8]);
    endfunction

    function automatic int zs(input int z);
        return int'(sif.count_out[z*8 +: 8]);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] ch, input logic [3:0] oo,
                        input logic [3:0] ce);
        rst         = r;
        wif.change  = ch;  sif.change  = ch;
        wif.on_off  = oo;  sif.on_off  = oo;
        wif.clr_err = ce;  sif.clr_err = ce;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 4'b0000, 4'b0000, 4'b0000);
    endtask

    task automatic pump(input int z, input logic up, input int n);
        logic [3:0] mask;
        mask = 4'b0001 << z;
        for (int i = 0; i < n; i++) step(1'b0, mask, up ? mask : 4'b0000, 4'b0000);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        wif.change = '0; wif.on_off = '0; wif.clr_err = '0;
        sif.change = '0; sif.on_off = '0; sif.clr_err = '0;

        // 1. reset ignores random events, then first increment and total latency
        for (int i = 0; i < 3; i++)
            step(1'b1, 4'($urandom), 4'($urandom), 4'b0000);
        check("rst_count_w", int'(wif.count_out), 0);
        check("rst_count_s", int'(sif.count_out), 0);
        check("rst_total_w", int'(wif.total_out), 0);
        check("rst_alarm_w", int'(wif.alarm), 0);
        check("rst_err_w", int'(wif.err), 0);
        idle();
        step(1'b0, 4'b0001, 4'b0001, 4'b0000);
        check("z0_first_inc", zw(0), 1);
        check("total_lag0", int'(wif.total_out), 0);
        idle();
        check("total_lag1", int'(wif.total_out), 1);

        // 2. wrap at max, wrap at zero, clear error
        pump(1, 1'b1, 255);
        check("z1_at_255_w", zw(1), 255);
        check("z1_err_pre_w", int'(wif.err[1]), 0);
        step(1'b0, 4'b0010, 4'b0010, 4'b0000);
        check("z1_wrap_up_w", zw(1), 0);
        check("z1_err_up_w", int'(wif.err[1]), 1);
        check("z1_alarm_hold_w", int'(wif.alarm[1]), 1);
        check("z1_clamp_up_s", zs(1), 255);
        check("z1_err_up_s", int'(sif.err[1]), 1);
        idle();
        check("z1_alarm_drop_w", int'(wif.alarm[1]), 0);
        check("z1_alarm_keep_s", int'(sif.alarm[1]), 1);
        step(1'b0, 4'b0010, 4'b0000, 4'b0000);
        check("z1_wrap_dn_w", zw(1), 255);
        check("z1_dec_s", zs(1), 254);
        step(1'b0, 4'b0000, 4'b0000, 4'b0010);
        check("z1_clr_w", int'(wif.err[1]), 0);
        check("z1_clr_s", int'(sif.err[1]), 0);
        check("z1_hold_w", zw(1), 255);
        check("total_w_256", int'(wif.total_out), 256);
        check("total_s_255", int'(sif.total_out), 255);

        // 3. saturate at both limits, set beats clear
        pump(2, 1'b1, 255);
        step(1'b0, 4'b0100, 4'b0100, 4'b0000);
        check("z2_clamp_hi_s", zs(2), 255);
        check("z2_err_hi_s", int'(sif.err[2]), 1);
        check("z2_wrap_hi_w", zw(2), 0);
        pump(2, 1'b0, 255);
        check("z2_at_0_s", zs(2), 0);
        check("z2_at_1_w", zw(2), 1);
        step(1'b0, 4'b0000, 4'b0000, 4'b0100);
        check("z2_clr_s", int'(sif.err[2]), 0);
        step(1'b0, 4'b0100, 4'b0000, 4'b0000);
        check("z2_clamp_lo_s", zs(2), 0);
        check("z2_err_lo_s", int'(sif.err[2]), 1);
        check("z2_noerr_w", int'(wif.err[2]), 0);
        step(1'b0, 4'b0100, 4'b0000, 4'b0100);
        check("z2_setwins_s", int'(sif.err[2]), 1);
        check("z2_setwins_w", int'(wif.err[2]), 1);
        check("z2_wrap_lo_w", zw(2), 255);
        check("z2_stay0_s", zs(2), 0);

        // 4. hysteresis on zone 3
        pump(3, 1'b1, 199);
        idle();
        check("z3_199", zw(3), 199);
        check("z3_alarm_199", int'(wif.alarm[3]), 0);
        step(1'b0, 4'b1000, 4'b1000, 4'b0000);
        check("z3_200", zw(3), 200);
        check("z3_alarm_lag", int'(wif.alarm[3]), 0);
        idle();
        check("z3_alarm_on_w", int'(wif.alarm[3]), 1);
        check("z3_alarm_on_s", int'(sif.alarm[3]), 1);
        pump(3, 1'b0, 49);
        idle();
        check("z3_151", zw(3), 151);
        check("z3_alarm_151", int'(wif.alarm[3]), 1);
        step(1'b0, 4'b1000, 4'b0000, 4'b0000);
        check("z3_alarm_150_lag", int'(wif.alarm[3]), 1);
        idle();
        check("z3_alarm_off_w", int'(wif.alarm[3]), 0);
        check("z3_alarm_off_s", int'(sif.alarm[3]), 0);

        // 5. concurrent events in every zone
        step(1'b1, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 10; i++) step(1'b0, 4'b1111, 4'b1111, 4'b0000);
        step(1'b0, 4'b1111, 4'b0101, 4'b0000);
        check("cc_z0", zw(0), 11);
        check("cc_z1", zw(1), 9);
        check("cc_z2", zw(2), 11);
        check("cc_z3", zs(3), 9);
        idle();
        idle();
        check("cc_hold_z0", zw(0), 11);
        check("cc_hold_z1", zs(1), 9);
        check("cc_total_w", int'(wif.total_out), 40);
        check("cc_total_s", int'(sif.total_out), 40);

        // 6. reset mid-operation from {50,200,3,255}
        for (int i = 0; i < 246; i++)
            step(1'b0, {1'b1, (i < 8) ? 1'b1 : 1'b0, (i < 191) ? 1'b1 : 1'b0,
                        (i < 39) ? 1'b1 : 1'b0}, 4'b1011, 4'b0000);
        check("pre_z0", zw(0), 50);
        check("pre_z1", zw(1), 200);
        check("pre_z2", zw(2), 3);
        check("pre_z3", zw(3), 255);
        step(1'b0, 4'b1000, 4'b1000, 4'b0000);
        idle();
        check("pre_alarm1_w", int'(wif.alarm[1]), 1);
        check("pre_err3_w", int'(wif.err[3]), 1);
        check("pre_err3_s", int'(sif.err[3]), 1);
        check("pre_z3_s", zs(3), 255);
        step(1'b1, 4'b1111, 4'b1111, 4'b0000);
        check("mid_rst_count_w", int'(wif.count_out), 0);
        check("mid_rst_count_s", int'(sif.count_out), 0);
        check("mid_rst_total_w", int'(wif.total_out), 0);
        check("mid_rst_alarm_w", int'(wif.alarm), 0);
        check("mid_rst_err_w", int'(wif.err), 0);
        check("mid_rst_err_s", int'(sif.err), 0);
        idle();
        check("post_rst_count_w", int'(wif.count_out), 0);
        check("post_rst_total_s", int'(sif.total_out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/active_device_tracker.md
Name: active_device_tracker

Overview:
Multi-zone successor to the single 8-bit active-IoT-device counter. Tracks one up/down counter per zone, with a wrap or saturate mode selected by parameter. Adds a sticky per-zone range-error flag, a per-zone occupancy alarm with hysteresis, and a registered all-zone total. Sits between the zone event decoders and the status/CSR readout logic.

Parameters:
WIDTH, 8, bits per zone counter
NUM_ZONES, 4, number of independent zone counters (1..16)
SATURATE, 0, 0 = wrap-around at the limits, 1 = clamp at 0 and 2^WIDTH-1
ALARM_HI, 200, alarm asserts when a zone count is >= ALARM_HI
ALARM_LO, 150, alarm deasserts when a zone count is <= ALARM_LO; must be < ALARM_HI

Ports:
clk  in  1  clock, all logic on the rising edge
rst  in  1  reset, synchronous, active-high
change  in  NUM_ZONES  per-zone event strobe; 1 = apply on_off this cycle
on_off  in  NUM_ZONES  per-zone direction; 1 = device on (+1), 0 = device off (-1)
clr_err  in  NUM_ZONES  per-zone clear of the sticky error flag
count_out  out  NUM_ZONES*WIDTH  zone z count is at bits [z*WIDTH +: WIDTH]
total_out  out  WIDTH+clog2(NUM_ZONES)  registered sum of all zone counts
alarm  out  NUM_ZONES  per-zone hysteresis alarm
err  out  NUM_ZONES  per-zone sticky range error

Behaviour:
- Reset: when rst=1 at a clock edge, all of count_out, total_out, alarm and err are 0. rst overrides every other input.
- Zone counter, per zone z, each cycle:
  - change[z]=0: hold the count.
  - change[z]=1, on_off[z]=1: count+1.
  - change[z]=1, on_off[z]=0: count-1.
  - The new count is visible on count_out in the cycle after the edge (latency 1).
- Zones are fully independent. Simultaneous events in different zones all apply in the same cycle.
- Limits when SATURATE=0:
  - Increment at 2^WIDTH-1 wraps to 0.
  - Decrement at 0 wraps to 2^WIDTH-1.
- Limits when SATURATE=1:
  - Increment at max holds max.
  - Decrement at 0 holds 0.
- err[z], in both modes:
  - Sets on any increment requested at max or decrement requested at 0.
  - Stays set until clr_err[z]=1 or rst.
  - If clr_err[z] and a new range event occur in the same cycle, set wins and err[z] stays 1.
- alarm[z] is a two-state FSM per zone, IDLE (alarm=0) and ALARM (alarm=1):
  - Evaluated on the registered count, so it lags count_out by one cycle.
  - IDLE -> ALARM when count >= ALARM_HI.
  - ALARM -> IDLE when count <= ALARM_LO.
  - Otherwise hold the current state.
  - A wrap from max to 0 in ALARM mode drops alarm on the following cycle.
- total_out:
  - Registered sum of the current count_out values, so it lags count_out by one cycle.
  - Computed at full width, so it never overflows.
- Arithmetic: all counts are unsigned, and all comparisons are unsigned at WIDTH bits.

Decomposition:
- Package monitor_pkg holds:
  - MODE_WRAP/MODE_SAT constants.
  - A clog2 constant function.
  - The TOTAL_W derivation (WIDTH+clog2(NUM_ZONES)).
- Sub-module zone_counter holds one counter, its limit logic, its err flag and its alarm FSM. The top level instantiates it NUM_ZONES times with a generate loop and adds the registered adder tree for total_out.

Test Plan:
1. Reset with default parameters: hold rst=1 with random change/on_off for 3 cycles -> count_out, total_out, alarm and err all 0. Release rst, then pulse change[0]=1, on_off[0]=1 -> zone0=1 next cycle, total_out=1 the cycle after that.
2. Wrap mode (SATURATE=0), 8-bit:
   - Zone1 preloaded by events to 255, then +1 -> 0 and err[1]=1.
   - Decrement from 0 -> 255.
   - clr_err[1] alone -> err[1]=0.
3. Saturate mode (SATURATE=1):
   - Zone2 at 255, +1 -> stays 255, err[2]=1.
   - Zone2 at 0, -1 -> stays 0.
   - clr_err[2] in the same cycle as another -1 at 0 -> err[2] stays 1.
4. Hysteresis on zone3:
   - Count up to 199 -> alarm[3]=0.
   - Reach 200 -> alarm[3]=1 one cycle later.
   - Count down to 151 -> alarm stays 1.
   - Reach 150 -> alarm[3]=0 one cycle later.
5. Concurrency: change=4'b1111, on_off=4'b0101 from all zones at 10 -> zones {11,9,11,9} (zones 0..3), total_out=40. The change=0 cycles that follow hold all values.
6. Reset mid-operation: zones at {50,200,3,255}, alarm[1]=1, err set; assert rst for one cycle concurrent with change events -> all outputs 0 next cycle and the events are ignored.
